// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the CORDIC cascade.
//   CORDIC_ADDRESS_WIDTH : default angle width - 1 (2**w = pi/2)
//   CORDIC_HALF_PI       : pi/2 in angle units for the default width
//   CORDIC_X_INIT        : default x_0, 1/K gain pre-compensation (0.6073 * 2**7)
//   sideband_t           : {valid, negate} carried alongside the element results
package cordic_pkg;

    localparam int unsigned CORDIC_ADDRESS_WIDTH = 8;
    localparam int unsigned CORDIC_HALF_PI       = 2 ** CORDIC_ADDRESS_WIDTH;
    localparam int          CORDIC_X_INIT        = 78;

    typedef struct packed {
        logic valid;
        logic negate;
    } sideband_t;

endpackage

// File: rtl/cordic_phase_prep_if.sv
// cordic_phase_prep_if: sample bus from the phase prep stage to the CORDIC cascade.
//   x_0, y_0, z_0, valid_0 : new sample into element 0
//   valid_n, negate_n      : sideband delayed to line up with the last element
//   master : driven by cordic_phase_prep; slave : consumed by the cascade / output stage
interface cordic_phase_prep_if #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned VALUE_WIDTH   = 8
);
    logic signed [VALUE_WIDTH:0]   x_0;
    logic signed [VALUE_WIDTH:0]   y_0;
    logic signed [ADDRESS_WIDTH:0] z_0;
    logic                          valid_0;
    logic                          valid_n;
    logic                          negate_n;

    modport master (output x_0, y_0, z_0, valid_0, valid_n, negate_n);
    modport slave  (input  x_0, y_0, z_0, valid_0, valid_n, negate_n);
endinterface

// File: rtl/cordic_sideband_delay.sv
// cordic_sideband_delay: STAGES-deep free-running shift register of {valid, negate}.
//   CLK   : system clock, rising edge
//   RESET : asynchronous, active-low; clears every stage
//   din   : sideband entering the line
//   dout  : sideband exactly STAGES cycles later
module cordic_sideband_delay
    import cordic_pkg::*;
#(
    parameter int unsigned STAGES = 8
) (
    input  logic      CLK,
    input  logic      RESET,
    input  sideband_t din,
    output sideband_t dout
);

    sideband_t line [STAGES];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                line[i] <= '0;
            end
        end else begin
            line[0] <= din;
            for (int unsigned i = 1; i < STAGES; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign dout = line[STAGES-1];

endmodule

// File: rtl/cordic_phase_prep.sv
// cordic_phase_prep: phase-accumulator NCO feeding CORDIC element 0.
//   CLK, RESET   : clock (rising edge), asynchronous active-low reset
//   freq_word    : phase increment, captured into freq_reg by freq_load
//   phase_offset : added to the truncated phase; full circle = 2**(ADDRESS_WIDTH+2)
//   sync_clr     : restart phase (sample uses acc = 0)
//   enable       : produce one sample this cycle
//   bus (master) : x_0/y_0/z_0/valid_0 to element 0, valid_n/negate_n after STAGES cycles
// Build option: CORDIC_PREP_DITHER_EN adds 16-bit LFSR dither below the truncation point.
module cordic_phase_prep
    import cordic_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = CORDIC_ADDRESS_WIDTH,
    parameter int unsigned VALUE_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH     = 16,
    parameter int unsigned STAGES        = 8,
    parameter int          X_INIT        = CORDIC_X_INIT
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [ACC_WIDTH-1:0]     freq_word,
    input  logic                     freq_load,
    input  logic [ADDRESS_WIDTH+1:0] phase_offset,
    input  logic                     sync_clr,
    input  logic                     enable,
    cordic_phase_prep_if.master      bus
);

    localparam int unsigned PW = ADDRESS_WIDTH + 2;
    localparam int unsigned DW = ACC_WIDTH - ADDRESS_WIDTH - 2;

    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   freq_reg;
    logic [ACC_WIDTH-1:0]   acc_sample;
    logic [ACC_WIDTH-1:0]   acc_dith;
    logic [PW-1:0]          phase;
    logic [ADDRESS_WIDTH:0] z_next;
    logic                   neg_next;
    logic                   neg_0;
    sideband_t              sb_in;
    sideband_t              sb_out;

`ifdef CORDIC_PREP_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lfsr <= 16'hACE1;
        end else if (enable) begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    always_comb begin
        acc_dith = acc_sample + ACC_WIDTH'(lfsr[DW-1:0]);
    end
`else
    always_comb begin
        acc_dith = acc_sample;
    end
`endif

    // Quadrants 1 and 2 (top two phase bits differ) are shifted by pi: dropping
    // the MSB and reading the rest as signed does exactly that, flagged by negate.
    always_comb begin
        acc_sample = sync_clr ? '0 : acc;
        phase      = acc_dith[ACC_WIDTH-1 -: PW] + phase_offset;
        z_next     = phase[ADDRESS_WIDTH:0];
        neg_next   = phase[PW-1] ^ phase[ADDRESS_WIDTH];
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc      <= '0;
            freq_reg <= '0;
        end else begin
            if (freq_load) begin
                freq_reg <= freq_word;
            end
            if (sync_clr) begin
                acc <= enable ? freq_reg : '0;
            end else if (enable) begin
                acc <= acc + freq_reg;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bus.x_0     <= '0;
            bus.y_0     <= '0;
            bus.z_0     <= '0;
            bus.valid_0 <= 1'b0;
            neg_0       <= 1'b0;
        end else begin
            bus.valid_0 <= enable;
            if (enable) begin
                bus.x_0 <= (VALUE_WIDTH+1)'(X_INIT);
                bus.y_0 <= '0;
                bus.z_0 <= z_next;
                neg_0   <= neg_next;
            end
        end
    end

    always_comb begin
        sb_in        = '0;
        sb_in.valid  = bus.valid_0;
        sb_in.negate = neg_0;
    end

    cordic_sideband_delay #(
        .STAGES(STAGES)
    ) u_delay (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (sb_in),
        .dout  (sb_out)
    );

    assign bus.valid_n  = sb_out.valid;
    assign bus.negate_n = sb_out.negate;

endmodule

// File: tb/tb_cordic_phase_prep.sv
module tb_cordic_phase_prep;

    logic        CLK;
    logic        RESET;
    logic [15:0] freq_word;
    logic        freq_load;
    logic [9:0]  phase_offset;
    logic        sync_clr;
    logic        enable;

    int n_vec;
    int n_err;

    cordic_phase_prep_if #(.ADDRESS_WIDTH(8), .VALUE_WIDTH(8)) bus ();

    cordic_phase_prep #(
        .ADDRESS_WIDTH (8),
        .VALUE_WIDTH   (8),
        .ACC_WIDTH     (16),
        .STAGES        (8),
        .X_INIT        (78)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .freq_word    (freq_word),
        .freq_load    (freq_load),
        .phase_offset (phase_offset),
        .sync_clr     (sync_clr),
        .enable       (enable),
        .bus          (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model state
    logic [15:0] m_acc;
    logic [15:0] m_freq;
    logic [15:0] m_lfsr;
    logic        m_valid0;
    logic        m_neg0;
    logic [1:0]  m_line [8];
    int          q_z [$];

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc    = '0;
        m_freq   = '0;
        m_lfsr   = 16'hACE1;
        m_valid0 = 1'b0;
        m_neg0   = 1'b0;
        for (int i = 0; i < 8; i++) m_line[i] = 2'b00;
        q_z.delete();
    endtask

    // Called at a negedge: drive, clock, update model, check at the next negedge.
    task automatic step(input bit en, input bit clr, input bit ld,
                        input logic [15:0] word, input logic [9:0] off);
        logic [15:0] a;
        int          p;
        int          z;
        bit          ng;
        enable       = en;
        sync_clr     = clr;
        freq_load    = ld;
        freq_word    = word;
        phase_offset = off;
        @(posedge CLK);
        a = clr ? 16'h0000 : m_acc;
`ifdef CORDIC_PREP_DITHER_EN
        a = a + {10'd0, m_lfsr[5:0]};
`endif
        p = (int'(a >> 6) + int'(off)) % 1024;
        if (p < 256) begin
            z = p;        ng = 1'b0;
        end else if (p < 768) begin
            z = p - 512;  ng = 1'b1;
        end else begin
            z = p - 1024; ng = 1'b0;
        end
        for (int i = 7; i > 0; i--) m_line[i] = m_line[i-1];
        m_line[0] = {m_valid0, m_neg0};
        m_valid0 = en;
        if (en) begin
            m_neg0 = ng;
            q_z.push_back(z);
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
        if (clr)     m_acc = en ? m_freq : 16'h0000;
        else if (en) m_acc = m_acc + m_freq;
        if (ld)      m_freq = word;
        @(negedge CLK);
        check_val("valid_0", int'(bus.valid_0), int'(m_valid0));
        if (bus.valid_0) begin
            if (q_z.size() == 0) begin
                check_val("sb_depth", q_z.size(), 1);
            end else begin
                check_val("z_0", int'($signed(bus.z_0)), q_z.pop_front());
                check_val("x_0", int'($signed(bus.x_0)), 78);
                check_val("y_0", int'($signed(bus.y_0)), 0);
            end
        end
        check_val("valid_n", int'(bus.valid_n), int'(m_line[7][1]));
        check_val("negate_n", int'(bus.negate_n), int'(m_line[7][0]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 10'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid_0"},  int'(bus.valid_0), 0);
        check_val({tag, "_valid_n"},  int'(bus.valid_n), 0);
        check_val({tag, "_negate_n"}, int'(bus.negate_n), 0);
        check_val({tag, "_x_0"},      int'(bus.x_0), 0);
        check_val({tag, "_y_0"},      int'(bus.y_0), 0);
        check_val({tag, "_z_0"},      int'(bus.z_0), 0);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        RESET        = 1'b1;
        enable       = 1'b0;
        sync_clr     = 1'b0;
        freq_load    = 1'b0;
        freq_word    = '0;
        phase_offset = '0;
        model_reset();
        #2 RESET = 1'b0;
        #1 check_all_zero("rst");
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;

        // Steady state at pi/8 per sample
        step(1'b0, 1'b0, 1'b1, 16'h1000, 10'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 10'd0);
        idle(10);

        // Single-pulse alignment
        step(1'b1, 1'b0, 1'b0, 16'h0000, 10'd0);
        idle(10);

        // Accumulator wrap
        step(1'b0, 1'b0, 1'b1, 16'hFFC0, 10'd0);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 10'd0);
        step(1'b0, 1'b0, 1'b1, 16'h0080, 10'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 10'd0);

        // sync_clr, enable and freq_load together
        step(1'b1, 1'b1, 1'b1, 16'h0100, 10'd0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 10'd0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 10'd0);

        // Offset of pi lands on z = 0 with negate set
        step(1'b1, 1'b1, 1'b0, 16'h0000, 10'd512);
        idle(9);

        // Reset in the middle of a stream
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 10'd0);
        #2 RESET = 1'b0;
        enable = 1'b0;
        #1 check_all_zero("midrst");
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        step(1'b0, 1'b0, 1'b1, 16'h0C00, 10'd0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, 10'd0);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0), 16'($urandom()), 10'($urandom()));
        end
        idle(10);
        check_val("sb_drain", q_z.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
